// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the lc3b datapath and the central stall/flush sequencer.
// master = datapath side, slave = pipeline_stall_ctrl.
interface pipeline_stall_ctrl_if #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned CNT_W      = 16
);
    logic                  if_memread;
    logic                  if_mem_resp;
    logic                  mem_memread;
    logic                  mem_memwrite;
    logic                  mem_mem_resp;
    logic                  indirect;
    logic                  load_use;
    logic                  br_taken;
    logic                  perf_clr;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] bubble;
    logic [NUM_STAGES-1:0] flush;
    logic                  pc_redirect;
    logic                  ind_phase;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output if_memread, if_mem_resp, mem_memread, mem_memwrite, mem_mem_resp,
               indirect, load_use, br_taken, perf_clr,
        input  stall, bubble, flush, pc_redirect, ind_phase, stall_cycles, flush_count
    );

    modport slave (
        input  if_memread, if_mem_resp, mem_memread, mem_memwrite, mem_mem_resp,
               indirect, load_use, br_taken, perf_clr,
        output stall, bubble, flush, pc_redirect, ind_phase, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/bubble/flush sequencer for the lc3b pipeline: one freeze point per cycle,
// deferred branch flushes around in-flight d-mem accesses, saturating perf counters.
module pipeline_stall_ctrl #(
    parameter int unsigned NUM_STAGES   = 5,
    parameter int unsigned MEM_LATCH    = 3,
    parameter int unsigned LU_LATCH     = 2,
    parameter int unsigned FLUSH_STAGES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pipeline_stall_ctrl_if.slave bus
);
    // A flush that reaches the MEM latch must wait for the access there and kills any indirect sequence.
    localparam logic FLUSH_HITS_MEM = (FLUSH_STAGES >= MEM_LATCH);

    typedef enum logic {
        D_IDLE = 1'b0,
        D_IND2 = 1'b1
    } dstate_t;

    dstate_t               dstate;
    dstate_t               dstate_nxt;
    logic                  flush_pend;
    logic                  flush_pend_nxt;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      stall_cnt_nxt;
    logic [CNT_W-1:0]      flush_cnt;
    logic [CNT_W-1:0]      flush_cnt_nxt;

    logic                  mem_busy;
    logic                  dmem_wait;
    logic                  if_wait;
    logic                  flush_block;
    logic                  flush_fire;
    logic [NUM_STAGES-1:0] stall_raw;
    logic [NUM_STAGES-1:0] bubble_raw;
    logic [NUM_STAGES-1:0] flush_mask;
    logic [NUM_STAGES-1:0] stall_v;
    logic [NUM_STAGES-1:0] bubble_v;
    logic [NUM_STAGES-1:0] flush_v;
    logic                  pc_redirect_v;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dstate     <= D_IDLE;
            flush_pend <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            dstate     <= dstate_nxt;
            flush_pend <= flush_pend_nxt;
            stall_cnt  <= stall_cnt_nxt;
            flush_cnt  <= flush_cnt_nxt;
        end
    end

    // Freeze point, flush decision, next state and counter updates
    always_comb begin
        mem_busy       = 1'b0;
        dmem_wait      = 1'b0;
        if_wait        = 1'b0;
        flush_block    = 1'b0;
        flush_fire     = 1'b0;
        stall_raw      = '0;
        bubble_raw     = '0;
        flush_mask     = '0;
        stall_v        = '0;
        bubble_v       = '0;
        flush_v        = '0;
        pc_redirect_v  = 1'b0;
        dstate_nxt     = dstate;
        flush_pend_nxt = flush_pend;
        stall_cnt_nxt  = stall_cnt;
        flush_cnt_nxt  = flush_cnt;

        mem_busy  = (bus.mem_memread | bus.mem_memwrite) & ~bus.mem_mem_resp;
        dmem_wait = mem_busy
                  | ((dstate == D_IDLE) & bus.indirect & bus.mem_mem_resp)
                  | ((dstate == D_IND2) & ~bus.mem_mem_resp);
        if_wait   = bus.if_memread & ~bus.if_mem_resp;

        // Stall is a prefix ending at the highest active freeze point; the bubble sits just past it.
        for (int unsigned j = 0; j < NUM_STAGES; j++) begin
            stall_raw[j]  = (dmem_wait && (j <= MEM_LATCH))
                          || (bus.load_use && (j + 1 <= LU_LATCH))
                          || (if_wait && (j == 0));
            flush_mask[j] = (j >= 1) && (j <= FLUSH_STAGES);
        end
        for (int unsigned j = 1; j < NUM_STAGES; j++) begin
            bubble_raw[j] = stall_raw[j-1] & ~stall_raw[j];
        end

        flush_block = FLUSH_HITS_MEM & mem_busy;
        flush_fire  = (bus.br_taken | flush_pend) & ~flush_block;

        if (flush_fire) begin
            stall_v       = stall_raw  & ~(flush_mask | NUM_STAGES'(1));
            bubble_v      = bubble_raw & ~(flush_mask | NUM_STAGES'(1));
            flush_v       = flush_mask;
            pc_redirect_v = 1'b1;
        end else begin
            stall_v  = stall_raw;
            bubble_v = bubble_raw;
        end

        if (!reset_n) begin
            stall_v       = '0;
            bubble_v      = '0;
            flush_v       = '1;
            pc_redirect_v = 1'b0;
        end

        case (dstate)
            D_IDLE:  if (bus.indirect && bus.mem_mem_resp) dstate_nxt = D_IND2;
            D_IND2:  if (bus.mem_mem_resp) dstate_nxt = D_IDLE;
            default: dstate_nxt = D_IDLE;
        endcase
        if (flush_fire && FLUSH_HITS_MEM) begin
            dstate_nxt = D_IDLE;
        end

        // Pending survives until the outstanding access completes; a new br_taken merges into it.
        flush_pend_nxt = (bus.br_taken | flush_pend) & flush_block;

        if (bus.perf_clr) begin
            stall_cnt_nxt = '0;
            flush_cnt_nxt = '0;
        end else begin
            if (stall_v[0] && !(&stall_cnt)) stall_cnt_nxt = stall_cnt + CNT_W'(1);
            if (flush_fire && !(&flush_cnt)) flush_cnt_nxt = flush_cnt + CNT_W'(1);
        end
    end

    assign bus.stall        = stall_v;
    assign bus.bubble       = bubble_v;
    assign bus.flush        = flush_v;
    assign bus.pc_redirect  = pc_redirect_v;
    assign bus.ind_phase    = (dstate == D_IND2);
    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_count  = flush_cnt;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: driver queues hand-computed expectations per cycle,
// monitor samples on the falling edge and compares.
module tb_pipeline_stall_ctrl;
    localparam int unsigned NS = 5;
    localparam int unsigned CW = 4;

    // input bit order: if_memread, if_mem_resp, mem_memread, mem_memwrite, mem_mem_resp,
    //                  indirect, load_use, br_taken, perf_clr
    localparam logic [8:0] NONE   = 9'h000;
    localparam logic [8:0] IFR    = 9'h100;
    localparam logic [8:0] IFRESP = 9'h080;
    localparam logic [8:0] RD     = 9'h040;
    localparam logic [8:0] WR     = 9'h020;
    localparam logic [8:0] RESP   = 9'h010;
    localparam logic [8:0] IND    = 9'h008;
    localparam logic [8:0] LU     = 9'h004;
    localparam logic [8:0] BR     = 9'h002;
    localparam logic [8:0] CLR    = 9'h001;

    typedef struct {
        string          name;
        logic [NS-1:0]  stall;
        logic [NS-1:0]  bubble;
        logic [NS-1:0]  flush;
        logic           pcr;
        logic           indp;
        logic           chk_cnt;
        logic [CW-1:0]  sc;
        logic [CW-1:0]  fc;
    } exp_t;

    logic clk;
    logic reset_n;
    exp_t expq[$];
    int   checks;
    int   failures;

    pipeline_stall_ctrl_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

    pipeline_stall_ctrl #(
        .NUM_STAGES(NS), .MEM_LATCH(3), .LU_LATCH(2), .FLUSH_STAGES(3), .CNT_W(CW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%h want=%h", nm, fld, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk(e.name, "stall",  32'(bus.stall),       32'(e.stall));
                chk(e.name, "bubble", 32'(bus.bubble),      32'(e.bubble));
                chk(e.name, "flush",  32'(bus.flush),       32'(e.flush));
                chk(e.name, "pc_redirect", 32'(bus.pc_redirect), 32'(e.pcr));
                chk(e.name, "ind_phase",   32'(bus.ind_phase),   32'(e.indp));
                if (e.chk_cnt) begin
                    chk(e.name, "stall_cycles", 32'(bus.stall_cycles), 32'(e.sc));
                    chk(e.name, "flush_count",  32'(bus.flush_count),  32'(e.fc));
                end
            end
        end
    end

    task automatic step(input string nm, input logic rn, input logic [8:0] in,
                        input logic [NS-1:0] es, input logic [NS-1:0] eb, input logic [NS-1:0] ef,
                        input logic epc, input logic eip,
                        input logic cc, input logic [CW-1:0] esc, input logic [CW-1:0] efc);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = rn;
        {bus.if_memread, bus.if_mem_resp, bus.mem_memread, bus.mem_memwrite, bus.mem_mem_resp,
         bus.indirect, bus.load_use, bus.br_taken, bus.perf_clr} = in;
        e.name = nm; e.stall = es; e.bubble = eb; e.flush = ef; e.pcr = epc; e.indp = eip;
        e.chk_cnt = cc; e.sc = esc; e.fc = efc;
        expq.push_back(e);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        {bus.if_memread, bus.if_mem_resp, bus.mem_memread, bus.mem_memwrite, bus.mem_mem_resp,
         bus.indirect, bus.load_use, bus.br_taken, bus.perf_clr} = NONE;

        // reset
        step("rst0", 0, NONE, 5'h00, 5'h00, 5'h1F, 0, 0, 1, 0, 0);
        step("rst1", 0, NONE, 5'h00, 5'h00, 5'h1F, 0, 0, 1, 0, 0);

        // i-mem wait for three cycles
        step("if_a", 1, IFR,          5'h01, 5'h02, 5'h00, 0, 0, 1, 0, 0);
        step("if_b", 1, IFR,          5'h01, 5'h02, 5'h00, 0, 0, 1, 1, 0);
        step("if_c", 1, IFR,          5'h01, 5'h02, 5'h00, 0, 0, 1, 2, 0);
        step("if_d", 1, IFR | IFRESP, 5'h00, 5'h00, 5'h00, 0, 0, 1, 3, 0);
        step("if_e", 1, NONE,         5'h00, 5'h00, 5'h00, 0, 0, 1, 3, 0);

        // d-mem read, response on the fourth cycle
        step("dm_a", 1, RD,        5'h0F, 5'h10, 5'h00, 0, 0, 0, 0, 0);
        step("dm_b", 1, RD,        5'h0F, 5'h10, 5'h00, 0, 0, 0, 0, 0);
        step("dm_c", 1, RD,        5'h0F, 5'h10, 5'h00, 0, 0, 0, 0, 0);
        step("dm_d", 1, RD | RESP, 5'h00, 5'h00, 5'h00, 0, 0, 1, 6, 0);

        // load-use alone, then combined with both memory waits
        step("lu_a", 1, LU,            5'h03, 5'h04, 5'h00, 0, 0, 1, 6, 0);
        step("lu_b", 1, NONE,          5'h00, 5'h00, 5'h00, 0, 0, 1, 7, 0);
        step("lu_c", 1, LU | IFR | RD, 5'h0F, 5'h10, 5'h00, 0, 0, 1, 7, 0);
        step("lu_d", 1, NONE,          5'h00, 5'h00, 5'h00, 0, 0, 1, 8, 0);

        // indirect: responses at cycles 2 and 5
        step("ind1", 1, RD | IND,        5'h0F, 5'h10, 5'h00, 0, 0, 0, 0, 0);
        step("ind2", 1, RD | IND | RESP, 5'h0F, 5'h10, 5'h00, 0, 0, 0, 0, 0);
        step("ind3", 1, RD | IND,        5'h0F, 5'h10, 5'h00, 0, 1, 0, 0, 0);
        step("ind4", 1, RD | IND,        5'h0F, 5'h10, 5'h00, 0, 1, 0, 0, 0);
        step("ind5", 1, RD | IND | RESP, 5'h00, 5'h00, 5'h00, 0, 1, 0, 0, 0);
        step("ind6", 1, NONE,            5'h00, 5'h00, 5'h00, 0, 0, 1, 12, 0);

        // branch during outstanding read: deferred to the response cycle
        step("df_a", 1, RD | BR,   5'h0F, 5'h10, 5'h00, 0, 0, 0, 0, 0);
        step("df_b", 1, RD,        5'h0F, 5'h10, 5'h00, 0, 0, 0, 0, 0);
        step("df_c", 1, RD | RESP, 5'h00, 5'h00, 5'h0E, 1, 0, 1, 14, 0);
        step("df_d", 1, NONE,      5'h00, 5'h00, 5'h00, 0, 0, 1, 14, 1);
        // branch with load-use: flush wins
        step("bl_a", 1, BR | LU,   5'h00, 5'h00, 5'h0E, 1, 0, 0, 0, 0);
        step("bl_b", 1, NONE,      5'h00, 5'h00, 5'h00, 0, 0, 1, 14, 2);
        // second branch arriving with a pending flush counts once
        step("mg_a", 1, RD | BR,        5'h0F, 5'h10, 5'h00, 0, 0, 0, 0, 0);
        step("mg_b", 1, RD | RESP | BR, 5'h00, 5'h00, 5'h0E, 1, 0, 0, 0, 0);
        step("mg_c", 1, NONE,           5'h00, 5'h00, 5'h00, 0, 0, 1, 15, 3);

        // counter clear beats increment, then saturation
        step("sat0", 1, CLR | IFR, 5'h01, 5'h02, 5'h00, 0, 0, 1, 15, 3);
        step("sat1", 1, IFR,       5'h01, 5'h02, 5'h00, 0, 0, 1, 0, 0);
        for (int i = 0; i < 18; i++) begin
            step("satn", 1, IFR, 5'h01, 5'h02, 5'h00, 0, 0, 0, 0, 0);
        end
        step("satf", 1, NONE, 5'h00, 5'h00, 5'h00, 0, 0, 1, 15, 0);
        step("clr0", 1, CLR,  5'h00, 5'h00, 5'h00, 0, 0, 1, 15, 0);
        step("clr1", 1, NONE, 5'h00, 5'h00, 5'h00, 0, 0, 1, 0, 0);

        // reset in the middle of the second indirect access
        step("ri_a", 1, RD | IND | RESP, 5'h0F, 5'h10, 5'h00, 0, 0, 0, 0, 0);
        step("ri_b", 1, RD | IND,        5'h0F, 5'h10, 5'h00, 0, 1, 0, 0, 0);
        step("ri_c", 0, RD | IND,        5'h00, 5'h00, 5'h1F, 0, 1, 0, 0, 0);
        step("ri_d", 1, NONE,            5'h00, 5'h00, 5'h00, 0, 0, 1, 0, 0);

        // immediate flush during the second indirect access abandons it
        step("fi_a", 1, RD | IND | RESP, 5'h0F, 5'h10, 5'h00, 0, 0, 0, 0, 0);
        step("fi_b", 1, IND | BR,        5'h00, 5'h10, 5'h0E, 1, 1, 0, 0, 0);
        step("fi_c", 1, NONE,            5'h00, 5'h00, 5'h00, 0, 0, 1, 1, 1);

        // d-mem write wait
        step("wr_a", 1, WR,        5'h0F, 5'h10, 5'h00, 0, 0, 0, 0, 0);
        step("wr_b", 1, WR | RESP, 5'h00, 5'h00, 5'h00, 0, 0, 1, 2, 1);

        repeat (3) @(posedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
